// File: rtl/ghost_dir_gen.sv
// Direction source for one maze ghost: frame-tick driven IDLE/SCATTER/CHASE mode machine
// with wall-aware, no-reverse direction choice. Define GHOST_CHASE_EN to build CHASE/greedy logic.

module ghost_dir_gen #(
  parameter int          HOLD_FRAMES    = 60,
  parameter int          SCATTER_FRAMES = 420,
  parameter int          CHASE_FRAMES   = 1200,
  parameter int          DWELL_FRAMES   = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       lifeDown,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  input  logic [9:0] targetX,
  input  logic [9:0] targetY,
  input  logic [3:0] blocked,
  output logic [7:0] dir,
  output logic [1:0] mode
);

  localparam int FCNT_MAX_HS = (HOLD_FRAMES > SCATTER_FRAMES) ? HOLD_FRAMES : SCATTER_FRAMES;
  localparam int FCNT_MAX    = (FCNT_MAX_HS > CHASE_FRAMES) ? FCNT_MAX_HS : CHASE_FRAMES;
  localparam int FCNT_W      = $clog2(FCNT_MAX + 1);
  localparam int DCNT_W      = $clog2(DWELL_FRAMES + 1);

  localparam logic [7:0] DIR_STOP = 8'h00;
  localparam logic [7:0] DIR_L    = 8'h04;
  localparam logic [7:0] DIR_R    = 8'h07;
  localparam logic [7:0] DIR_D    = 8'h16;
  localparam logic [7:0] DIR_U    = 8'h1A;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_SCATTER = 2'd1,
    MODE_CHASE   = 2'd2
  } mode_e;

  logic              sync1_q, sync2_q, edge_q;
  logic [15:0]       lfsr_q;
  mode_e             mode_q, mode_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [7:0]        dir_q, dir_d;

  logic       tick;
  logic       lfsr_fb;
  logic       force_dec;
  logic       need_dec;
  logic [3:0] cur_mask, rev_mask, unblk, fwd_mask, allowed;
  logic [3:0] rnd_mask, pick_mask;

  assign tick    = sync2_q & ~edge_q;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  function automatic logic [7:0] mask_to_code(input logic [3:0] m);
    if (m[0])      return DIR_L;
    else if (m[1]) return DIR_R;
    else if (m[2]) return DIR_D;
    else if (m[3]) return DIR_U;
    else           return DIR_STOP;
  endfunction

  // Phase sequencing; only committed on a tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mode_d    = mode_q;
    fcnt_d    = fcnt_q + FCNT_W'(1);
    force_dec = 1'b0;
    case (mode_q)
      MODE_IDLE: begin
        if (fcnt_q == FCNT_W'(HOLD_FRAMES - 1)) begin
          mode_d    = MODE_SCATTER;
          fcnt_d    = '0;
          force_dec = 1'b1;
        end
      end
      MODE_SCATTER: begin
        if (fcnt_q == FCNT_W'(SCATTER_FRAMES - 1)) begin
`ifdef GHOST_CHASE_EN
          mode_d    = MODE_CHASE;
`else
          mode_d    = MODE_SCATTER;
`endif
          fcnt_d    = '0;
          force_dec = 1'b1;
        end
      end
`ifdef GHOST_CHASE_EN
      MODE_CHASE: begin
        if (fcnt_q == FCNT_W'(CHASE_FRAMES - 1)) begin
          mode_d    = MODE_SCATTER;
          fcnt_d    = '0;
          force_dec = 1'b1;
        end
      end
`endif
      default: begin
        mode_d = MODE_IDLE;
        fcnt_d = '0;
      end
    endcase
  end

  // Bit order of all direction masks: 0 L, 1 R, 2 D, 3 U.
  always_comb begin
    case (dir_q)
      DIR_L:   cur_mask = 4'b0001;
      DIR_R:   cur_mask = 4'b0010;
      DIR_D:   cur_mask = 4'b0100;
      DIR_U:   cur_mask = 4'b1000;
      default: cur_mask = 4'b0000;
    endcase
  end

  assign rev_mask = {cur_mask[2], cur_mask[3], cur_mask[0], cur_mask[1]};
  assign unblk    = ~blocked;
  assign fwd_mask = unblk & ~rev_mask;
  assign allowed  = (fwd_mask != 4'b0000) ? fwd_mask : (unblk & rev_mask);

  // Walk from the farthest rotation to the nearest so the first allowed candidate wins.
  always_comb begin
    rnd_mask = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      if (allowed[2'(lfsr_q[1:0] + 2'(k))])
        rnd_mask = 4'b0001 << 2'(lfsr_q[1:0] + 2'(k));
    end
  end

`ifdef GHOST_CHASE_EN
  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic [3:0]         x_mask, y_mask, prim_mask, sec_mask, first_mask, greedy_mask;

  assign dx         = {1'b0, targetX} - {1'b0, ghostX};
  assign dy         = {1'b0, targetY} - {1'b0, ghostY};
  assign adx        = dx[10] ? 11'(-dx) : dx;
  assign ady        = dy[10] ? 11'(-dy) : dy;
  assign x_mask     = (dx == 11'sd0) ? 4'b0000 : (dx[10] ? 4'b0001 : 4'b0010);
  assign y_mask     = (dy == 11'sd0) ? 4'b0000 : (dy[10] ? 4'b1000 : 4'b0100);
  assign prim_mask  = (adx >= ady) ? x_mask : y_mask;
  assign sec_mask   = (adx >= ady) ? y_mask : x_mask;
  assign first_mask = allowed & (~allowed + 4'd1);

  always_comb begin
    if (dx == 11'sd0 && dy == 11'sd0)       greedy_mask = rnd_mask;
    else if ((prim_mask & allowed) != 4'b0) greedy_mask = prim_mask;
    else if ((sec_mask & allowed) != 4'b0)  greedy_mask = sec_mask;
    else                                    greedy_mask = first_mask;
  end

  assign pick_mask = (mode_d == MODE_CHASE) ? greedy_mask : rnd_mask;
`else
  logic unused_target;
  assign unused_target = ^{targetX, targetY};
  assign pick_mask     = rnd_mask;
`endif

  assign need_dec = force_dec
                  | (dcnt_q == DCNT_W'(DWELL_FRAMES - 1))
                  | ((cur_mask & blocked) != 4'b0000)
                  | (cur_mask == 4'b0000);

  always_comb begin
    dir_d  = dir_q;
    dcnt_d = dcnt_q + DCNT_W'(1);
    if (mode_d == MODE_IDLE) begin
      dir_d  = DIR_STOP;
      dcnt_d = '0;
    end else if (need_dec) begin
      dir_d  = mask_to_code(pick_mask);
      dcnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      mode_q  <= MODE_IDLE;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      dir_q   <= DIR_STOP;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
      if (lifeDown) begin
        mode_q <= MODE_IDLE;
        fcnt_q <= '0;
        dcnt_q <= '0;
        dir_q  <= DIR_STOP;
      end else if (tick) begin
        mode_q <= mode_d;
        fcnt_q <= fcnt_d;
        dcnt_q <= dcnt_d;
        dir_q  <= dir_d;
      end
    end
  end

  assign dir  = dir_q;
  assign mode = mode_q;

endmodule
